// File: rtl/pmem_arbiter_pkg.sv
// Shared types and default widths for the physical-memory read-port arbiter.
package pmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 64;

endpackage

// File: rtl/pmem_arbiter_if.sv
// Requester and memory-side signals of the arbiter bundled as one interface.
// master: the arbiter's view; slave: the requesters/memory environment.
interface pmem_arbiter_if import pmem_arb_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
);

  logic [NUM_REQ-1:0]             req_rd_en;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0]              req_data;
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_err;
  logic                           busy;
  logic                           mem_rd_en;
  logic [ADDR_W-1:0]              mem_addr;
  logic [DATA_W-1:0]              mem_data;
  logic                           mem_data_valid;

  modport master (
    input  req_rd_en, req_addr, mem_data, mem_data_valid,
    output req_data, req_valid, req_err, busy, mem_rd_en, mem_addr
  );

  modport slave (
    output req_rd_en, req_addr, mem_data, mem_data_valid,
    input  req_data, req_valid, req_err, busy, mem_rd_en, mem_addr
  );

endinterface

// File: rtl/pmem_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above rr_ptr,
// wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any_req
);

  int idx;

  // NOTE: every output gets a default before the search so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    any_req  = 1'b0;
    idx      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!any_req && req[idx]) begin
        any_req    = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one physical-memory read port between NUM_REQ
// requesters, with a single outstanding transaction and an optional timeout.
module pmem_arbiter import pmem_arb_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  pmem_arbiter_if.master  bus
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit   TIMEOUT_EN = (TIMEOUT != 0);

  arb_state_e         state, state_nxt;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    gnt_id;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  req_data_q;
  logic               resp_err_q;

  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]    pick_id;
  logic               pick_any;
  logic [ADDR_W-1:0]  pick_addr;
  logic               timeout_hit;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req      (bus.req_rd_en),
    .rr_ptr   (rr_ptr),
    .grant    (pick_grant),
    .grant_id (pick_id),
    .any_req  (pick_any)
  );

  always_comb begin
    pick_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) pick_addr = pick_addr | bus.req_addr[i];
    end
  end

  assign timeout_hit = TIMEOUT_EN && (cnt == CNT_LAST);

  // NOTE: flops use non-blocking assignments so every register samples the
  // pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (pick_any) state_nxt = BUSY;
      BUSY: if (bus.mem_data_valid || timeout_hit) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction datapath: grant, address, timeout counter and response latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      gnt_id     <= '0;
      cnt        <= '0;
      mem_addr_q <= '0;
      req_data_q <= '0;
      resp_err_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            gnt_id     <= pick_id;
            mem_addr_q <= pick_addr;
            cnt        <= '0;
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (bus.mem_data_valid) begin
            req_data_q <= bus.mem_data;
            resp_err_q <= 1'b0;
          end else if (timeout_hit) begin
            resp_err_q <= 1'b1;
          end
        end
        RESP: begin
          rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Pulses and handshake decode from state, so reset clears them at once.
  always_comb begin
    bus.busy      = (state != IDLE);
    bus.mem_rd_en = (state == BUSY);
    bus.mem_addr  = mem_addr_q;
    bus.req_data  = req_data_q;
    bus.req_valid = '0;
    bus.req_err   = '0;
    if (state == RESP) begin
      if (resp_err_q) bus.req_err[gnt_id]   = 1'b1;
      else            bus.req_valid[gnt_id] = 1'b1;
    end
  end

endmodule
